// File: rtl/seg_byte_rx_pkg.sv
// seg_byte_rx_pkg: shared state encoding, frame geometry and hex glyph table
package seg_byte_rx_pkg;

    localparam int FRAME_BITS = 14;
    localparam int SEG_BITS   = 7;

    typedef enum logic [1:0] {IDLE, SHIFT, DECODE, HOLD} state_t;

    // Active-low gfedcba patterns of the sixteen legal hex glyphs
    localparam logic [SEG_BITS-1:0] SEG_0 = 7'h40;
    localparam logic [SEG_BITS-1:0] SEG_1 = 7'h79;
    localparam logic [SEG_BITS-1:0] SEG_2 = 7'h24;
    localparam logic [SEG_BITS-1:0] SEG_3 = 7'h30;
    localparam logic [SEG_BITS-1:0] SEG_4 = 7'h19;
    localparam logic [SEG_BITS-1:0] SEG_5 = 7'h12;
    localparam logic [SEG_BITS-1:0] SEG_6 = 7'h02;
    localparam logic [SEG_BITS-1:0] SEG_7 = 7'h78;
    localparam logic [SEG_BITS-1:0] SEG_8 = 7'h00;
    localparam logic [SEG_BITS-1:0] SEG_9 = 7'h10;
    localparam logic [SEG_BITS-1:0] SEG_A = 7'h08;
    localparam logic [SEG_BITS-1:0] SEG_B = 7'h03;
    localparam logic [SEG_BITS-1:0] SEG_C = 7'h46;
    localparam logic [SEG_BITS-1:0] SEG_D = 7'h21;
    localparam logic [SEG_BITS-1:0] SEG_E = 7'h06;
    localparam logic [SEG_BITS-1:0] SEG_F = 7'h0E;

    // Table indexed by nibble value
    localparam logic [SEG_BITS-1:0] SEG_LUT [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };

endpackage

// File: rtl/seg_byte_rx_seg_to_nibble.sv
// seg_to_nibble: maps one 7-segment pattern to its hex value, flagging illegal glyphs
module seg_to_nibble
    import seg_byte_rx_pkg::*;
(
    input  logic [SEG_BITS-1:0] i_seg,
    output logic [3:0]          o_nib,
    output logic                o_inv
);

    // Table search; unmatched patterns yield value 0 with the invalid flag set
    always_comb begin
        o_nib = '0;
        o_inv = 1'b1;
        for (int i = 0; i < 16; i++)
            if (i_seg == SEG_LUT[i]) begin
                o_nib = 4'(i);
                o_inv = 1'b0;
            end
    end

endmodule

// File: rtl/seg_byte_rx.sv
// seg_byte_rx: serial receiver of two 7-segment glyphs decoded to one byte with a valid/ready output
module seg_byte_rx #(
    parameter int FRAME_BITS = seg_byte_rx_pkg::FRAME_BITS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sdata,
    input  logic       sen,
    output logic       in_ready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_err,
    output logic       abort
);
    import seg_byte_rx_pkg::*;

    localparam logic [3:0] LAST_CNT = 4'(FRAME_BITS - 1);

    state_t                  r_state, w_next;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [3:0]              r_cnt;
    logic [7:0]              r_byte;
    logic                    r_valid, r_err, r_abort;
    logic                    w_abort;
    logic [3:0]              w_hi_nib, w_lo_nib;
    logic                    w_hi_inv, w_lo_inv;

    seg_to_nibble u_hi (.i_seg(r_shift[FRAME_BITS-1 -: SEG_BITS]), .o_nib(w_hi_nib), .o_inv(w_hi_inv));
    seg_to_nibble u_lo (.i_seg(r_shift[SEG_BITS-1:0]),             .o_nib(w_lo_nib), .o_inv(w_lo_inv));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state, input readiness and abort detection
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        w_abort  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (sen) w_next = SHIFT;
            end
            SHIFT: begin
                in_ready = 1'b1;
                if (!sen) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end else if (r_cnt == LAST_CNT) w_next = DECODE;
            end
            DECODE: w_next = HOLD;
            HOLD:   if (r_valid && out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Shift register, bit count, registered result and abort pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_abort;
            case (r_state)
                IDLE: if (sen) begin
                    r_shift <= {{(FRAME_BITS-1){1'b0}}, sdata};
                    r_cnt   <= 4'd1;
                end
                SHIFT: begin
                    r_shift <= sen ? {r_shift[FRAME_BITS-2:0], sdata} : '0;
                    r_cnt   <= sen ? r_cnt + 4'd1 : '0;
                end
                DECODE: begin
                    r_byte  <= {w_hi_nib, w_lo_nib};
                    r_err   <= w_hi_inv | w_lo_inv;
                    r_valid <= 1'b1;
                    r_cnt   <= '0;
                end
                HOLD: if (out_ready) r_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign out_byte  = r_byte;
    assign out_valid = r_valid;
    assign out_err   = r_err;
    assign abort     = r_abort;

endmodule

// File: tb/tb_seg_byte_rx.sv
// tb_seg_byte_rx: directed and randomized checks of seg_byte_rx against a glyph-table model
module tb_seg_byte_rx;

    logic       clk = 1'b0, reset = 1'b1, sdata = 1'b0, sen = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_valid, out_err, abort;
    logic [7:0] out_byte;
    int         n_assert = 0, n_fail = 0;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seg_byte_rx #(.FRAME_BITS(14)) dut (
        .clk(clk), .reset(reset), .sdata(sdata), .sen(sen), .in_ready(in_ready),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .out_err(out_err), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Returns {err, nibble}: legal glyph gives its index, anything else gives 0 with err
    function automatic logic [4:0] glyph_val(input logic [6:0] p);
        logic [4:0] r;
        r = 5'h10;
        for (int i = 0; i < 16; i++)
            if (GLYPH[i] == p) r = {1'b0, 4'(i)};
        return r;
    endfunction

    task automatic send_bits(input logic [13:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            sen   = 1'b1;
            sdata = f[13-i];
            chk("in_ready_bit", {31'b0, in_ready}, 32'd1);
            step;
        end
        sen   = 1'b0;
        sdata = 1'b0;
    endtask

    task automatic run_frame(input logic [6:0] hi, input logic [6:0] lo);
        logic [4:0] h, l;
        logic [7:0] eb;
        logic       ee;
        h  = glyph_val(hi);
        l  = glyph_val(lo);
        eb = {h[3:0], l[3:0]};
        ee = h[4] | l[4];
        out_ready = 1'b1;
        send_bits({hi, lo}, 14);
        chk("valid_edge1", {31'b0, out_valid}, 32'd0);
        chk("in_ready_decode", {31'b0, in_ready}, 32'd0);
        step;
        chk("valid_edge2", {31'b0, out_valid}, 32'd1);
        chk("byte", {24'b0, out_byte}, {24'b0, eb});
        chk("err", {31'b0, out_err}, {31'b0, ee});
        step;
        chk("valid_single", {31'b0, out_valid}, 32'd0);
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        chk("byte_retained", {24'b0, out_byte}, {24'b0, eb});
        chk("no_abort", {31'b0, abort}, 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_byte", {24'b0, out_byte}, 32'd0);
        chk("rst_err", {31'b0, out_err}, 32'd0);
        chk("rst_abort", {31'b0, abort}, 32'd0);
        step;
        step;
        reset = 1'b0;
        step;

        // "2","0" with consumer ready: single valid pulse, 0x20
        run_frame(7'h24, 7'h40);

        // "F","b" held for five cycles with ignored strobes
        out_ready = 1'b0;
        send_bits({7'h0E, 7'h03}, 14);
        chk("hold_lat1", {31'b0, out_valid}, 32'd0);
        step;
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_byte", {24'b0, out_byte}, 32'hFB);
            chk("hold_err", {31'b0, out_err}, 32'd0);
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            sen   = 1'b1;
            sdata = 1'($urandom);
            if (k == 4) out_ready = 1'b1;
            step;
        end
        sen = 1'b0;
        chk("hs_valid_clr", {31'b0, out_valid}, 32'd0);
        chk("hs_byte_kept", {24'b0, out_byte}, 32'hFB);
        chk("hs_in_ready", {31'b0, in_ready}, 32'd1);
        step;
        chk("hs_bit_not_captured", {31'b0, abort}, 32'd0);

        // Illegal high glyph
        run_frame(7'h7F, 7'h79);
        chk("illegal_err", {31'b0, out_err}, 32'd1);
        chk("illegal_byte", {24'b0, out_byte}, 32'h01);

        // Abort after nine bits, then a clean frame
        send_bits({7'h24, 7'h40}, 9);
        chk("abort_pre", {31'b0, abort}, 32'd0);
        step;
        chk("abort_pulse", {31'b0, abort}, 32'd1);
        chk("abort_no_valid", {31'b0, out_valid}, 32'd0);
        step;
        chk("abort_one_cycle", {31'b0, abort}, 32'd0);
        chk("abort_no_valid2", {31'b0, out_valid}, 32'd0);
        run_frame(7'h10, 7'h08);
        chk("after_abort_byte", {24'b0, out_byte}, 32'h9A);

        // Reset mid-frame, then "8","8"
        send_bits({7'h19, 7'h12}, 7);
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_byte", {24'b0, out_byte}, 32'd0);
        chk("mid_rst_abort", {31'b0, abort}, 32'd0);
        step;
        chk("mid_rst_abort2", {31'b0, abort}, 32'd0);
        reset = 1'b0;
        step;
        chk("post_rst_abort", {31'b0, abort}, 32'd0);
        run_frame(7'h00, 7'h00);
        chk("post_rst_byte", {24'b0, out_byte}, 32'h88);

        // Random 7-bit patterns, legal or not
        for (int r = 0; r < 40; r++)
            run_frame(7'($urandom), (r % 2 == 0) ? GLYPH[$urandom_range(15)] : 7'($urandom));

        // Every legal digit pair back-to-back
        for (int h = 0; h < 16; h++)
            for (int l = 0; l < 16; l++) begin
                run_frame(GLYPH[h], GLYPH[l]);
                chk("pair_byte", {24'b0, out_byte}, 32'(h * 16 + l));
                chk("pair_err", {31'b0, out_err}, 32'd0);
            end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_byte_rx.md
SEG_BYTE_RX -- requirements
Module: seg_byte_rx

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 14: bits per frame, two 7-bit segment patterns.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port sdata  input  1  serial segment data bit.
REQ-005 SHALL have port sen  input  1  bit strobe; sdata is sampled on every clk edge with sen=1 and in_ready=1.
REQ-006 SHALL have port in_ready  output  1  high when the block accepts frame bits.
REQ-007 SHALL have port out_byte  output  8  decoded value, {high nibble, low nibble}.
REQ-008 SHALL have port out_valid  output  1  out_byte/out_err hold a completed frame.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result when high with out_valid.
REQ-010 SHALL have port out_err  output  1  at least one pattern in the frame is not a legal hex glyph.
REQ-011 SHALL have port abort  output  1  one-cycle pulse when a frame is abandoned.

Function
REQ-012 Frame SHALL be 14 bits, MSB first: high digit segments g,f,e,d,c,b,a, then low digit segments g..a. Segments are active-low, 0 = lit.
REQ-013 Legal patterns (gfedcba, hex) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-014 The state machine SHALL have states IDLE, SHIFT, DECODE and HOLD.
REQ-015 IDLE: in_ready=1; sen=1 SHALL capture bit 0, set the count to 1 and go to SHIFT.
REQ-016 SHIFT: in_ready=1; each sen=1 cycle SHALL shift in one bit and increment the 4-bit count.
REQ-017 SHIFT: when the 14th bit is captured, the block SHALL go to DECODE.
REQ-018 SHIFT: sen=0 with count<14 SHALL pulse abort for one cycle, clear the shift register and count, and return to IDLE. Partial bits SHALL be discarded.
REQ-019 DECODE: in_ready=0 and both patterns SHALL be decoded in one cycle.
REQ-020 DECODE: out_byte, out_err and out_valid=1 SHALL be registered and the block SHALL go to HOLD. Latency from the last accepted bit to out_valid SHALL be exactly 2 clk edges.
REQ-021 An illegal pattern SHALL make that nibble 0 and set out_err=1. out_err SHALL be the OR of both digit errors.
REQ-022 HOLD: in_ready=0; out_byte, out_err and out_valid SHALL remain stable until out_valid and out_ready are both high.
REQ-023 HOLD: on that handshake cycle out_valid SHALL clear on the next edge and the block SHALL go to IDLE. sen is ignored while in_ready=0.
REQ-024 out_ready already high when out_valid rises SHALL complete the handshake in that first HOLD cycle, leaving exactly one out_valid cycle.
REQ-025 out_byte and out_err SHALL retain their last values after the handshake. Only out_valid clears.
REQ-026 A bit arriving in the same cycle as the handshake SHALL NOT be captured. Capture SHALL resume from IDLE on the next cycle.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, count=0, shift register=0, out_byte=8'h00, out_valid=0, out_err=0 and abort=0. in_ready SHALL be 1 during and after reset.
REQ-028 Reset mid-frame or in HOLD SHALL discard all state without an abort pulse.

Structure
REQ-029 A shared package SHALL hold the state enum, FRAME_BITS, SEG_BITS=7, and the 16 legal pattern constants.
REQ-030 A combinational sub-module seg_to_nibble (7-bit pattern in, 4-bit value and invalid flag out) SHALL be instantiated twice.

Verification
REQ-031 Frame 0x24,0x40 (digits "2","0") with out_ready=1 SHALL give out_byte=8'h20, out_err=0 and a single out_valid pulse 2 edges after the last bit.
REQ-032 Frame 0x0E,0x03 with out_ready=0 for 5 cycles SHALL hold out_byte=8'hFB and out_valid=1 for 5 cycles with in_ready=0, and sen pulses meanwhile SHALL be ignored.
REQ-033 Frame 0x7F,0x79 SHALL give out_byte=8'h01 and out_err=1.
REQ-034 sen dropped after 9 bits SHALL give a one-cycle abort and no out_valid. A following full frame 0x10,0x08 SHALL give 8'h9A.
REQ-035 reset asserted at bit 7 and then a full frame 0x00,0x00 SHALL give 8'h88 with no abort pulse.
REQ-036 All 256 digit pairs sent back-to-back with out_ready=1 SHALL each decode correctly, with err=0.
